// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch/realign stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetchState_t;

  localparam int BUF_WORDS = 2;

  // Low two bits of a 32-bit instruction; anything else is an RVC halfword.
  localparam logic [1:0] RVC_MASK = 2'b11;

  function automatic logic is_rvc(input logic [15:0] half);
    return half[1:0] != RVC_MASK;
  endfunction

endpackage

// File: rtl/fetchBuffer.sv
// Two-entry word FIFO; each entry carries the word address it was fetched from.
module fetchBuffer (
  input  logic        clk,
  input  logic        arstn,
  input  logic        flush_i,
  input  logic        push_i,
  input  logic [31:0] push_data_i,
  input  logic [31:0] push_addr_i,
  input  logic        pop_i,
  output logic [31:0] head_data_o,
  output logic [31:0] head_addr_o,
  output logic [15:0] next_half_o,
  output logic [1:0]  count_o
);

  logic [31:0] data0_q, data1_q;
  logic [31:0] addr0_q, addr1_q;
  logic [1:0]  count_q;

  // Entry 0 is always the head; a pop shifts entry 1 down.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      data0_q <= '0;
      data1_q <= '0;
      addr0_q <= '0;
      addr1_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      count_q <= '0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) begin
            data0_q <= push_data_i;
            addr0_q <= push_addr_i;
            count_q <= count_q + 2'd1;
          end else if (count_q == 2'd1) begin
            data1_q <= push_data_i;
            addr1_q <= push_addr_i;
            count_q <= count_q + 2'd1;
          end
        end
        2'b01: begin
          if (count_q != 2'd0) begin
            data0_q <= data1_q;
            addr0_q <= addr1_q;
            count_q <= count_q - 2'd1;
          end
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            data0_q <= data1_q;
            addr0_q <= addr1_q;
            data1_q <= push_data_i;
            addr1_q <= push_addr_i;
          end else begin
            data0_q <= push_data_i;
            addr0_q <= push_addr_i;
            count_q <= 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_data_o = data0_q;
  assign head_addr_o = addr0_q;
  assign next_half_o = data1_q[15:0];
  assign count_o     = count_q;

endmodule

// File: rtl/fetch_align_unit.sv
// Fetch stage: word-aligned memory requests, a two-word buffer, and
// realignment of 16/32-bit instructions (including word-straddling ones).
//
// Handshakes: a transfer happens on a clock edge where valid and ready are
// both high; valid never depends on ready, and the payload stays stable while
// valid is high and ready is low. imemReq/imemGnt and instrValid/instrReady
// follow this rule; imemRvalid is unconditionally accepted.
module fetch_align_unit #(
  parameter int BUF_WORDS = fetch_pkg::BUF_WORDS
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic [31:0]            pcIF,
  input  logic                   redirect,
  output logic                   imemReq,
  output logic [31:0]            imemAddr,
  input  logic                   imemGnt,
  input  logic                   imemRvalid,
  input  logic [31:0]            imemRdata,
  output logic                   instrValid,
  input  logic                   instrReady,
  output logic [31:0]            instr,
  output logic [31:0]            instrPc,
  output logic                   instrCompressed,
  output fetch_pkg::fetchState_t fsm_state_o
);

  import fetch_pkg::*;

  fetchState_t state_q;
  logic [31:0] faddr_q;
  logic        hoff_q, hoff_d;
  logic        outstanding_q;

  logic [31:0] head_data, head_addr;
  logic [15:0] next_half;
  logic [1:0]  buf_count;
  logic        buf_full, buf_push, buf_pop;

  logic [15:0] head_low;
  logic        low_rvc, avail, fire, grant, outst_after_redirect;
  logic [31:0] raw_instr;

  // Bit 0 of the PC can never address an instruction and is dropped.
  logic unused_pc_bit;
  assign unused_pc_bit = pcIF[0];

  fetchBuffer u_buf (
    .clk         (clk),
    .arstn       (arstn),
    .flush_i     (redirect),
    .push_i      (buf_push),
    .push_data_i (imemRdata),
    .push_addr_i (faddr_q - 32'd4),
    .pop_i       (buf_pop),
    .head_data_o (head_data),
    .head_addr_o (head_addr),
    .next_half_o (next_half),
    .count_o     (buf_count)
  );

  assign buf_full = (buf_count == 2'(BUF_WORDS));
  assign imemReq  = (state_q == FETCH) && !buf_full;
  assign imemAddr = faddr_q;
  assign grant    = imemReq && imemGnt;
  // Returning data belongs to the word just below faddr (faddr already advanced on grant).
  assign buf_push = (state_q == WAIT) && imemRvalid && !redirect;
  // A request still in flight after this cycle means the next rvalid is stale.
  assign outst_after_redirect = (outstanding_q && !imemRvalid) || grant;

  // Realign the head halfword into one instruction and decide consumption.
  always_comb begin
    head_low  = hoff_q ? head_data[31:16] : head_data[15:0];
    low_rvc   = is_rvc(head_low);
    raw_instr = head_data;
    if (low_rvc) begin
      raw_instr = {16'h0000, head_low};
    end else if (hoff_q) begin
      raw_instr = {next_half, head_low};
    end
    avail = (buf_count != 2'd0) && (low_rvc || !hoff_q || buf_full);
    instrValid      = avail && !redirect;
    instr           = instrValid ? raw_instr : '0;
    instrPc         = instrValid ? (head_addr + {30'd0, hoff_q, 1'b0}) : '0;
    instrCompressed = instrValid && low_rvc;
    fire    = instrValid && instrReady;
    // Offset moves 1 (RVC) or 2 halfwords; crossing the word end pops the head.
    buf_pop = fire && (hoff_q || !low_rvc);
    hoff_d  = fire ? (hoff_q ^ low_rvc) : hoff_q;
  end

  // Fetch FSM: address, halfword offset and outstanding-request tracking.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_q       <= BOOT;
      faddr_q       <= '0;
      hoff_q        <= 1'b0;
      outstanding_q <= 1'b0;
    end else if (redirect) begin
      faddr_q       <= {pcIF[31:2], 2'b00};
      hoff_q        <= pcIF[1];
      outstanding_q <= outst_after_redirect;
      state_q       <= outst_after_redirect ? DRAIN : FETCH;
    end else begin
      hoff_q <= hoff_d;
      case (state_q)
        BOOT: begin
          faddr_q <= {pcIF[31:2], 2'b00};
          hoff_q  <= pcIF[1];
          state_q <= FETCH;
        end
        FETCH: begin
          if (grant) begin
            faddr_q       <= faddr_q + 32'd4;
            outstanding_q <= 1'b1;
            state_q       <= WAIT;
          end
        end
        WAIT, DRAIN: begin
          if (imemRvalid) begin
            outstanding_q <= 1'b0;
            state_q       <= FETCH;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  assign fsm_state_o = state_q;

endmodule
